// File: rtl/mux8_rr_arbiter.sv
// Round-robin burst arbiter driving a shared 8-way select datapath onto one stream.
// Define MUX8_ARB_FIXED_PRIO_EN to add pri_mode (lowest-index priority in IDLE).
module mux8_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] in_data,
  input  logic               out_ready,
`ifdef MUX8_ARB_FIXED_PRIO_EN
  input  logic               pri_mode,
`endif
  output logic [7:0]         ack,
  output logic [2:0]         addr,
  output logic               nCS,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [2:0]       addr_q, addr_d;
  logic [2:0]       last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ncs_q, ncs_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic [2:0]       rr_idx;
  logic [2:0]       cand;
  logic             rr_hit;
  logic [2:0]       pick_idx;
  logic             beat;
  logic             burst_done;
  logic [7:0]       cnt_inc;
  logic [WIDTH-1:0] lane;

  // Scan upward from last+1; k=8 wraps back onto last itself.
  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    cand   = '0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_q + 3'(k);
      if (!rr_hit && req[cand]) begin
        rr_idx = cand;
        rr_hit = 1'b1;
      end
    end
  end

`ifdef MUX8_ARB_FIXED_PRIO_EN
  logic [2:0] fp_idx;

  always_comb begin
    fp_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) fp_idx = 3'(i);
    end
  end

  assign pick_idx = pri_mode ? fp_idx : rr_idx;
`else
  assign pick_idx = rr_idx;
`endif

  assign lane       = in_data[addr_q*WIDTH +: WIDTH];
  assign beat       = (state_q == BUSY) && req[addr_q] && out_ready;
  assign cnt_inc    = cnt_q + 8'd1;
  assign burst_done = (cnt_inc == 8'(MAX_BURST));
  assign ack        = beat ? (8'd1 << addr_q) : 8'd0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ncs_d   = ncs_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          addr_d  = pick_idx;
          ncs_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (beat) begin
          data_d  = lane;
          valid_d = 1'b1;
          cnt_d   = cnt_inc;
        end
        if (!req[addr_q] || (beat && burst_done)) begin
          state_d = IDLE;
          ncs_d   = 1'b1;
          last_d  = addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= 3'd7;
      cnt_q   <= '0;
      ncs_q   <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ncs_q   <= ncs_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign addr      = addr_q;
  assign nCS       = ncs_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized + directed bench for mux8_rr_arbiter against a behavioural model.
module tb_mux8_rr_arbiter;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     req;
  logic [8*W-1:0] in_data;
  logic           out_ready;
  logic [7:0]     ack;
  logic [2:0]     addr;
  logic           nCS;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           pm = 1'b0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .in_data(in_data),
    .out_ready(out_ready),
`ifdef MUX8_ARB_FIXED_PRIO_EN
    .pri_mode(pm),
`endif
    .ack(ack),
    .addr(addr),
    .nCS(nCS),
    .out_data(out_data),
    .out_valid(out_valid)
  );

  int vecs = 0;
  int errs = 0;

  bit           m_ok = 0;
  bit           m_busy;
  int           m_lane, m_cnt, m_last, m_addr;
  bit           m_oval;
  logic [W-1:0] m_odata;
  logic         prev_ncs = 1'b1;
  int           grants[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r);
    if (pm) begin
      for (int i = 0; i < 8; i++) if (r[i]) return i;
    end
    for (int k = 1; k <= 8; k++) if (r[(m_last + k) % 8]) return (m_last + k) % 8;
    return 0;
  endfunction

  task automatic model_step(input bit rst, input logic [7:0] rq, input bit rdy,
                            input logic [8*W-1:0] dat);
    bit bt;
    if (rst) begin
      m_ok = 1; m_busy = 0; m_addr = 0; m_oval = 0;
      m_odata = '0; m_cnt = 0; m_last = 7;
    end else if (!m_busy) begin
      m_oval = 0;
      if (rq != 0) begin
        m_lane = pick(rq); m_addr = m_lane; m_busy = 1; m_cnt = 0;
      end
    end else begin
      bt = rq[m_lane] && rdy;
      m_oval = bt;
      if (bt) begin
        m_odata = dat[m_lane*W +: W];
        m_cnt++;
      end
      if (!rq[m_lane] || (bt && m_cnt == MB)) begin
        m_busy = 0; m_last = m_lane;
      end
    end
  endtask

  task automatic cyc(input bit rst, input logic [7:0] rq, input bit rdy);
    logic [7:0] eack;
    @(negedge clk);
    reset = rst; req = rq; out_ready = rdy;
    in_data = {$urandom(), $urandom()};
    #1;
    if (m_ok) begin
      eack = (m_busy && rq[m_lane] && rdy) ? 8'(1 << m_lane) : 8'd0;
      chk("ack", ack, eack);
      chk("addr", addr, m_addr);
      chk("nCS", nCS, !m_busy);
      chk("out_valid", out_valid, m_oval);
      if (m_oval) chk("out_data", out_data, m_odata);
    end
    if (prev_ncs && !nCS) grants.push_back(int'(addr));
    prev_ncs = nCS;
    model_step(rst, rq, rdy, in_data);
  endtask

  logic [6:0] s_ncs, s_ack, s_val;
  logic [7:0] rq_r;
  int n;

  initial begin
    reset = 1'b1; req = '0; out_ready = 1'b1; in_data = '0;

    // sole requester: timing pinned by literals
    cyc(1, 8'h00, 1);
    for (int c = 0; c < 7; c++) begin
      cyc(0, 8'h01, 1);
      s_ncs[c] = nCS; s_ack[c] = ack[0]; s_val[c] = out_valid;
    end
    chk("A_ncs_seq", s_ncs, 7'b0100001);
    chk("A_ack_seq", s_ack, 7'b1011110);
    chk("A_val_seq", s_val, 7'b0111100);

    // all requesting: order 0..7,0
    cyc(1, 8'h00, 1);
    grants.delete();
    for (int c = 0; c < 80 && grants.size() < 9; c++) cyc(0, 8'hFF, 1);
    chk("B_ngrants", grants.size(), 9);
    for (int i = 0; i < 9 && i < grants.size(); i++) chk("B_order", grants[i], i % 8);

    // stall on lane 3
    cyc(1, 8'h00, 1);
    cyc(0, 8'h08, 0);
    for (int c = 0; c < 10; c++) begin
      cyc(0, 8'h08, 0);
      chk("C_stall_ack", ack, 8'h00);
      chk("C_stall_addr", {nCS, addr}, 4'b0011);
    end
    n = 0;
    for (int c = 0; c < 10 && !nCS; c++) begin
      cyc(0, 8'h08, 1);
      if (ack[3]) n++;
    end
    chk("C_beats", n, 4);

    // lane 5 drops after 2 beats, lane 6 next
    cyc(1, 8'h00, 1);
    grants.delete();
    cyc(0, 8'h60, 1);
    cyc(0, 8'h60, 1);
    cyc(0, 8'h60, 1);
    cyc(0, 8'h40, 1);
    cyc(0, 8'h40, 1);
    chk("D_idle", nCS, 1'b1);
    cyc(0, 8'h40, 1);
    chk("D_ngrants", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("D_first", grants[0], 5);
      chk("D_second", grants[1], 6);
    end

    // reset mid-burst on lane 2
    cyc(1, 8'h00, 1);
    cyc(0, 8'h04, 1);
    cyc(0, 8'h04, 1);
    cyc(0, 8'h04, 1);
    cyc(1, 8'h04, 1);
    cyc(0, 8'h04, 1);
    chk("E_after_rst", {nCS, out_valid, addr}, 5'b10000);
    cyc(0, 8'h04, 1);
    chk("E_regrant", {nCS, addr}, 4'b0010);

`ifdef MUX8_ARB_FIXED_PRIO_EN
    pm = 1'b1;
    cyc(1, 8'h00, 1);
    grants.delete();
    for (int c = 0; c < 40; c++) cyc(0, 8'h82, 1);
    chk("F_ngrants", grants.size() >= 6, 1'b1);
    for (int i = 0; i < grants.size(); i++) chk("F_lane", grants[i], 1);
    pm = 1'b0;
`endif

    // random traffic
    cyc(1, 8'h00, 1);
    rq_r = 8'h00;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(3) == 0) rq_r = 8'($urandom());
      cyc($urandom_range(63) == 0, rq_r, $urandom_range(3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
